// File: rtl/md_unit_p_if.sv
// ============================================================================
// Module      : md_unit_p_if
// Description : Request/result bundle between the E-stage control and the
//               multiply/divide unit.
//               master : start, op, a, b, flush out; busy, hi, lo in
//               slave  : start, op, a, b, flush in;  busy, hi, lo out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_p_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, flush, output busy, hi, lo);
endinterface

`default_nettype wire

// File: rtl/md_unit_p.sv
// ============================================================================
// Module      : md_unit_p
// Description : Multiply/divide unit owning the HI/LO pair. Multiply-class
//               ops take MULT_CYC busy cycles; DIV/DIVU run a restoring
//               radix-2 divider (WIDTH cycles) plus one sign-fix cycle.
//               Optional multiply-accumulate (ops 7-10) when MD_MADD_EN is
//               defined; otherwise those ops are NOPs.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset
//               md    - md_unit_p_if.slave (start/op/a/b/flush in,
//                       busy/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit_p #(
    parameter int WIDTH    = 32,
    parameter int MULT_CYC = 5,
    parameter int CNT_W    = 6
) (
    input  wire logic   clk,
    input  wire logic   reset,
    md_unit_p_if.slave  md
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

    localparam logic [1:0] c_ACC_NONE = 2'd0;
    localparam logic [1:0] c_ACC_ADD  = 2'd1;
    localparam logic [1:0] c_ACC_SUB  = 2'd2;

    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_hi, r_lo;
    logic [2*WIDTH-1:0]     r_pend;
    logic [1:0]             r_acc;
    logic [WIDTH-1:0]       r_rem, r_quo, r_dvsr, r_a_org;
    logic                   r_neg_q, r_neg_r, r_dz;

    // Operation decode
    logic                   w_is_mul, w_mul_signed, w_is_div, w_div_signed;
    logic                   w_is_mthi, w_is_mtlo;
    logic [1:0]             w_acc_mode;

    always_comb begin
        w_is_mul     = 1'b0;
        w_mul_signed = 1'b0;
        w_is_div     = 1'b0;
        w_div_signed = 1'b0;
        w_is_mthi    = 1'b0;
        w_is_mtlo    = 1'b0;
        w_acc_mode   = c_ACC_NONE;
        case (md.op)
            c_OP_MULT:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; end
            c_OP_MULTU: w_is_mul = 1'b1;
            c_OP_DIV:   begin w_is_div = 1'b1; w_div_signed = 1'b1; end
            c_OP_DIVU:  w_is_div = 1'b1;
            c_OP_MTHI:  w_is_mthi = 1'b1;
            c_OP_MTLO:  w_is_mtlo = 1'b1;
`ifdef MD_MADD_EN
            c_OP_MADD:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; w_acc_mode = c_ACC_ADD; end
            c_OP_MADDU: begin w_is_mul = 1'b1; w_acc_mode = c_ACC_ADD; end
            c_OP_MSUB:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; w_acc_mode = c_ACC_SUB; end
            c_OP_MSUBU: begin w_is_mul = 1'b1; w_acc_mode = c_ACC_SUB; end
`endif
            default: ;
        endcase
    end

    logic w_accept;
    assign w_accept = (r_state == S_IDLE) && md.start && !md.flush;

    // Product: extend both operands to 2*WIDTH (sign or zero) so a single
    // modulo-2^(2W) multiply serves signed and unsigned forms.
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
    assign w_ext_a = w_mul_signed ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
    assign w_ext_b = w_mul_signed ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Divider operand magnitudes. -2^(W-1) maps onto itself, which is its
    // correct unsigned magnitude, so the overflow case falls out naturally
    // (quotient 2^(W-1), remainder 0, both signs negative -> no negation).
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = w_div_signed & md.a[WIDTH-1];
    assign w_b_neg = w_div_signed & md.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - md.a) : md.a;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - md.b) : md.b;

    // One restoring step: r_quo doubles as the dividend shift register,
    // its MSB feeding the partial remainder while quotient bits enter at LSB.
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
    assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvsr};
    assign w_rem_nxt = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    logic [WIDTH-1:0] w_q_fix, w_r_fix;
    assign w_q_fix = r_neg_q ? (WIDTH'(0) - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;

    // Next-state and completion strobes
    logic w_commit_mul, w_commit_div;

    always_comb begin
        w_state_nxt  = r_state;
        w_commit_mul = 1'b0;
        w_commit_div = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
                else if (w_accept && w_is_div) w_state_nxt = S_DIV;
            end
            S_MUL: begin
                if (md.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt  = S_IDLE;
                    w_commit_mul = 1'b1;
                end
            end
            S_DIV: begin
                if (md.flush)                w_state_nxt = S_IDLE;
                else if (r_cnt == c_CNT_ONE) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt  = S_IDLE;
                w_commit_div = !md.flush;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_pend  <= '0;
            r_acc   <= c_ACC_NONE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_a_org <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_is_mthi) r_hi <= md.a;
                if (w_is_mtlo) r_lo <= md.a;
                if (w_is_mul) begin
                    r_pend <= w_prod;
                    r_acc  <= w_acc_mode;
                    r_cnt  <= c_MUL_CNT;
                end
                if (w_is_div) begin
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
                    r_dvsr  <= w_b_mag;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_dz    <= (md.b == '0);
                    r_a_org <= md.a;
                    r_cnt   <= c_DIV_CNT;
                end
            end else if (r_state == S_MUL || r_state == S_DIV) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end

            if (r_state == S_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end

            if (w_commit_mul) begin
                case (r_acc)
                    c_ACC_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                    c_ACC_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
                    default:   {r_hi, r_lo} <= r_pend;
                endcase
            end

            if (w_commit_div) begin
                r_lo <= r_dz ? '1 : w_q_fix;
                r_hi <= r_dz ? r_a_org : w_r_fix;
            end
        end
    end

    assign md.busy = (r_state != S_IDLE);
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_p.sv
// ============================================================================
// Module      : tb_md_unit_p
// Description : Directed self-checking bench for md_unit_p (WIDTH=32,
//               MULT_CYC=5). MADD checks are built when MD_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit_p;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_p_if #(.WIDTH(W)) ifc ();

    md_unit_p #(.WIDTH(W), .MULT_CYC(5), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    // Present one request for a single edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ifc.start = 1'b1;
        ifc.op    = op;
        ifc.a     = a;
        ifc.b     = b;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
    endtask

    // Counts edges until busy drops, bounded at 200.
    task automatic wait_idle(output int n);
        n = 0;
        while (ifc.busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
        n_vec++; if (ifc.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", ifc.lo); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int n;
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_start got=%b exp=1", ifc.busy); end
        n_vec++; if (ifc.lo !== 32'h0) begin n_err++; $display("FAIL mult_no_partial lo got=%h exp=0", ifc.lo); end
        wait_idle(n);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL mult_cycles got=%0d exp=5", n); end
        n_vec++; if (ifc.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got=%h exp=ffffffeb", ifc.lo); end
    endtask

    task automatic test_multu();
        int n;
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL multu_cycles got=%0d exp=5", n); end
        n_vec++; if (ifc.hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi got=%h exp=00000001", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got=%h exp=fffffffe", ifc.lo); end
    endtask

    task automatic test_div();
        int n;
        // -7 / 2 -> q=-3, r=-1
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        n_vec++; if (n !== 33) begin n_err++; $display("FAIL div_cycles got=%0d exp=33", n); end
        n_vec++; if (ifc.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", ifc.hi); end
        // 7 / -2 -> q=-3, r=1
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        n_vec++; if (ifc.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div2_lo got=%h exp=fffffffd", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'h0000_0001) begin n_err++; $display("FAIL div2_hi got=%h exp=00000001", ifc.hi); end
        // DIVU 100 / 3 -> q=33, r=1
        issue(4'd4, 32'd100, 32'd3);
        wait_idle(n);
        n_vec++; if (ifc.lo !== 32'd33) begin n_err++; $display("FAIL divu_lo got=%h exp=00000021", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'd1) begin n_err++; $display("FAIL divu_hi got=%h exp=00000001", ifc.hi); end
    endtask

    task automatic test_div_corner();
        int n;
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        n_vec++; if (ifc.lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got=%h exp=80000000", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi got=%h exp=0", ifc.hi); end
        issue(4'd4, 32'd10, 32'd0);
        wait_idle(n);
        n_vec++; if (n !== 33) begin n_err++; $display("FAIL divz_cycles got=%0d exp=33", n); end
        n_vec++; if (ifc.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo got=%h exp=ffffffff", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'd10) begin n_err++; $display("FAIL divz_hi got=%h exp=0000000a", ifc.hi); end
    endtask

    task automatic test_flush();
        issue(4'd5, 32'h11, 32'h0);
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got=%b exp=0", ifc.busy); end
        issue(4'd6, 32'h22, 32'h0);
        n_vec++; if (ifc.hi !== 32'h11) begin n_err++; $display("FAIL mthi_hi got=%h exp=11", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'h22) begin n_err++; $display("FAIL mtlo_lo got=%h exp=22", ifc.lo); end
        // DIVU 100/3, flush raised during busy cycle 10
        issue(4'd4, 32'd100, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy got=%b exp=1", ifc.busy); end
        ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", ifc.busy); end
        n_vec++; if (ifc.hi !== 32'h11) begin n_err++; $display("FAIL flush_hi got=%h exp=11", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'h22) begin n_err++; $display("FAIL flush_lo got=%h exp=22", ifc.lo); end
        // Flush coincident with multiply completion edge
        issue(4'd2, 32'd3, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL flush_done_busy got=%b exp=0", ifc.busy); end
        n_vec++; if (ifc.lo !== 32'h22) begin n_err++; $display("FAIL flush_done_lo got=%h exp=22", ifc.lo); end
        // Flush in IDLE blocks MTHI and MULT
        ifc.flush = 1'b1;
        issue(4'd5, 32'hDEAD, 32'h0);
        issue(4'd1, 32'd2, 32'd2);
        ifc.flush = 1'b0;
        n_vec++; if (ifc.hi !== 32'h11) begin n_err++; $display("FAIL flush_idle_hi got=%h exp=11", ifc.hi); end
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got=%b exp=0", ifc.busy); end
    endtask

    task automatic test_madd();
`ifdef MD_MADD_EN
        int n;
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'd5, 32'h0);
        issue(4'd7, 32'd3, 32'd4);
        wait_idle(n);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL madd_cycles got=%0d exp=5", n); end
        n_vec++; if (ifc.lo !== 32'd17) begin n_err++; $display("FAIL madd_lo got=%h exp=00000011", ifc.lo); end
        n_vec++; if (ifc.hi !== 32'd0) begin n_err++; $display("FAIL madd_hi got=%h exp=0", ifc.hi); end
        issue(4'd10, 32'd1, 32'd18);
        wait_idle(n);
        n_vec++; if (ifc.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msubu_hi got=%h exp=ffffffff", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msubu_lo got=%h exp=ffffffff", ifc.lo); end
`else
        issue(4'd5, 32'hAA, 32'h0);
        issue(4'd6, 32'hBB, 32'h0);
        issue(4'd7, 32'd3, 32'd4);
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL madd_nop_busy got=%b exp=0", ifc.busy); end
        issue(4'd10, 32'd1, 32'd18);
        repeat (6) begin @(posedge clk); #1; end
        n_vec++; if (ifc.hi !== 32'hAA) begin n_err++; $display("FAIL madd_nop_hi got=%h exp=aa", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'hBB) begin n_err++; $display("FAIL madd_nop_lo got=%h exp=bb", ifc.lo); end
`endif
    endtask

    task automatic test_reset_mid();
        issue(4'd6, 32'h55, 32'h0);
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", ifc.busy); end
        n_vec++; if (ifc.hi !== 32'h0) begin n_err++; $display("FAIL rst_mid_hi got=%h exp=0", ifc.hi); end
        n_vec++; if (ifc.lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_lo got=%h exp=0", ifc.lo); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (ifc.lo !== 32'h0) begin n_err++; $display("FAIL rst_after_lo got=%h exp=0", ifc.lo); end
    endtask

    initial begin
        reset     = 1'b1;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.flush = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corner();
        test_flush();
        test_madd();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
